alu_add_stage: RTL and testbench
================================

# alu_add_stage

Registered 64-bit add/subtract execute stage wrapped around the team's 64-bit carry-lookahead adder (`carry_lookahead_adder_64bit`). It sits directly upstream of the writeback/flag logic. It accepts operand pairs over a valid/ready handshake and drives the adder's `a`, `b` and `cin`. It registers the sum with Z/N/C/V flags and keeps an architectural carry flag so that ADC/SBC can chain multi-word arithmetic.

## Interface
Parameters:
- none; the datapath is fixed at 64 bits by the adder.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  stage can accept a beat this cycle.
- `in_op`  in  2  operation: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
- `in_a`  in  64  operand A.
- `in_b`  in  64  operand B.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `out_sum`  out  64  registered result.
- `out_flags`  out  4  registered {Z, N, C, V}, with Z in bit 3.
- `carry_flag`  out  1  current architectural carry (C of the last accepted op).

## Operation
- Adder operands:
  - ADD: a=A, b=B, cin=0.
  - SUB: a=A, b=~B, cin=1.
  - ADC: a=A, b=B, cin=carry_flag.
  - SBC: a=A, b=~B, cin=carry_flag.
- C is the adder `cout`. For SUB and SBC, C=1 means no borrow.
- V = (a[63] == b'[63]) && (s[63] != a[63]), where b' is the post-inversion adder operand.
- Z = (s == 0). N = s[63].
- The adder `G` and `P` outputs are unused.
- Accept condition: `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational and adds no bubble under continuous flow.
- On accept:
  - `out_sum` and `out_flags` are loaded from the adder.
  - `carry_flag` is loaded with C.
  - `out_valid` is set to 1.
- On `out_valid && out_ready` with no accept in the same cycle: `out_valid` is cleared to 0. `out_sum` and `out_flags` hold their last value.
- Simultaneous consume and accept: the new result replaces the old one and `out_valid` stays 1.
- Stall (`out_valid && !out_ready`):
  - `in_ready` is 0.
  - `out_sum`, `out_flags` and `carry_flag` hold.
  - Input beats are not accepted and cause no side effects.
- `carry_flag` changes only on accept. ADC/SBC always use the carry of the immediately previously accepted op, even if that result has not yet been consumed.
- All arithmetic is modulo 2^64, with wrap-around reported only through C and V.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on `out_*` after edge k.
- Throughput is 1 op/cycle while `out_ready` is held high.
- Reset values (asynchronous assert, synchronous deassert handled upstream):
  - `out_valid`=0, `out_sum`=0, `out_flags`=4'b0000, `carry_flag`=0.
  - `in_ready`=1 while in reset.
- Reset mid-stall discards the held result, and the pending input is not accepted.
- `out_valid` must not drop without `out_ready`. `out_sum` and `out_flags` must be stable while `out_valid && !out_ready`.
- Combinational path: in_op/in_a/in_b → adder → result registers. The full CLA delay plus flag logic must fit in one cycle.
- `in_ready` depends combinationally on `out_ready` only, with no path from `in_valid`.

## Test plan
- Reset: assert `rst_n`=0 mid-stream.
  - Required: `out_valid`=0, `out_sum`=0, `out_flags`=0, `carry_flag`=0 immediately (asynchronous), and `in_ready`=1.
- ADD wrap: A=64'hFFFF_FFFF_FFFF_FFFF, B=1.
  - Required: `out_sum`=0 and flags Z=1, N=0, C=1, V=0 one cycle later; `carry_flag`=1.
- SUB overflow: A=64'h8000_0000_0000_0000, B=1.
  - Required: `out_sum`=64'h7FFF_FFFF_FFFF_FFFF, Z=0, N=0, C=1, V=1.
- 128-bit chain: ADD of low words FFFF_FFFF_FFFF_FFFF + 1, then ADC of high words 0 + 0 issued back-to-back.
  - Required: second result is 1, with C=0.
- Repeat the chain with SUB low 0−1, then SBC high 5−0.
  - Required: second result is 4, with C=1.
- Backpressure: hold `out_ready`=0 for 3 cycles after a result, with `in_valid`=1 and changing operands.
  - Required: `in_ready`=0, and `out_sum`, `out_flags` and `carry_flag` frozen for those 3 cycles.
  - Then raise `out_ready`. Required: the pending beat is accepted the same cycle, with no lost or duplicated results.
- Streaming: 100 random ops with random `out_ready` against a reference model.
  - Required: every accepted beat produces exactly one result in order, with matching sum, flags and carry chaining.

Source files
------------

// File: rtl/alu_add_stage.sv
// ---------------------------------------------------------------------------
// alu_add_stage
//   Registered 64-bit ADD/SUB/ADC/SBC execute stage built around a
//   carry-lookahead adder. Operands arrive over a valid/ready handshake.
//   The result register holds the sum and the {Z, N, C, V} flags. An
//   architectural carry flag feeds ADC/SBC so multi-word arithmetic can chain.
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand beat offered
//   in_ready    stage can accept this cycle (!out_valid || out_ready)
//   in_op       00 ADD, 01 SUB, 10 ADC, 11 SBC
//   in_a, in_b  64-bit operands
//   out_valid   result register holds an unconsumed result
//   out_ready   downstream consumes the result this cycle
//   out_sum     registered 64-bit result
//   out_flags   registered {Z, N, C, V}
//   carry_flag  carry of the last accepted operation
//
// carry_lookahead_adder_64bit
//   Three-level 4-bit lookahead adder (bit -> 4-bit group -> 16-bit block).
//   Ports: a, b, cin in; s, cout, G (group generate), P (group propagate) out.
// ---------------------------------------------------------------------------

module carry_lookahead_adder_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
    output logic        cout,
    output logic        G,
    output logic        P
);

    // Carry into positions 0..3 of a 4-wide lookahead cell.
    function automatic logic [3:0] carries4(input logic [2:0] g, input logic [2:0] p,
                                            input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group {generate, propagate} of a 4-wide cell.
    function automatic logic [1:0] group4(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    logic [63:0] bit_g, bit_p, bit_c;
    logic [15:0] grp_g, grp_p, grp_c;
    logic [3:0]  blk_g, blk_p, blk_c;
    logic [3:0]  cell_c;

    always_comb begin
        bit_g  = a & b;
        bit_p  = a ^ b;
        grp_c  = '0;
        bit_c  = '0;
        cell_c = '0;
        for (int j = 0; j < 16; j++) begin
            {grp_g[j], grp_p[j]} = group4(bit_g[4*j +: 4], bit_p[4*j +: 4]);
        end
        for (int k = 0; k < 4; k++) begin
            {blk_g[k], blk_p[k]} = group4(grp_g[4*k +: 4], grp_p[4*k +: 4]);
        end
        {G, P} = group4(blk_g, blk_p);
        blk_c  = carries4(blk_g[2:0], blk_p[2:0], cin);
        for (int k = 0; k < 4; k++) begin
            cell_c = carries4(grp_g[4*k +: 3], grp_p[4*k +: 3], blk_c[k]);
            grp_c[4*k +: 4] = cell_c;
        end
        for (int j = 0; j < 16; j++) begin
            cell_c = carries4(bit_g[4*j +: 3], bit_p[4*j +: 3], grp_c[j]);
            bit_c[4*j +: 4] = cell_c;
        end
        s    = bit_p ^ bit_c;
        cout = G | (P & cin);
    end

endmodule

module alu_add_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic [3:0]  out_flags,
    output logic        carry_flag
);

    // {Z, N, C, V}; overflow uses the post-inversion B operand so SUB/SBC
    // get the correct signed-overflow rule for free.
    function automatic logic [3:0] calc_flags(input logic [63:0] a, input logic [63:0] b_eff,
                                              input logic [63:0] s, input logic c);
        logic v;
        v = (a[63] == b_eff[63]) && (s[63] != a[63]);
        return {(s == 64'd0), s[63], c, v};
    endfunction

    logic        valid_q, valid_d;
    logic [63:0] sum_q, sum_d;
    logic [3:0]  flags_q, flags_d;
    logic        carry_q, carry_d;

    logic [63:0] b_eff;
    logic        cin_eff;
    logic [63:0] add_s;
    logic        add_c;
    logic        cla_g_unused, cla_p_unused;
    logic        accept;

    // op[0] selects subtract (invert B), op[1] selects carry-in from the flag.
    always_comb begin
        b_eff   = in_op[0] ? ~in_b : in_b;
        cin_eff = in_op[1] ? carry_q : in_op[0];
    end

    carry_lookahead_adder_64bit u_cla (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin_eff),
        .s    (add_s),
        .cout (add_c),
        .G    (cla_g_unused),
        .P    (cla_p_unused)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        sum_d   = sum_q;
        flags_d = flags_q;
        carry_d = carry_q;
        if (accept) begin
            valid_d = 1'b1;
            sum_d   = add_s;
            flags_d = calc_flags(in_a, b_eff, add_s, add_c);
            carry_d = add_c;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Result register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= 64'd0;
            flags_q <= 4'b0000;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
            carry_q <= carry_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_sum    = sum_q;
    assign out_flags  = flags_q;
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_add_stage.sv
module tb_alu_add_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic [3:0]  out_flags;
    logic        carry_flag;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    alu_add_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_flags  (out_flags),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: returns {sum, Z, N, C, V} using a plain 65-bit addition.
    function automatic logic [67:0] ref_op(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic cf);
        logic [63:0] bb;
        logic        ci;
        logic [64:0] r;
        logic        v;
        bb = op[0] ? ~b : b;
        ci = op[1] ? cf : op[0];
        r  = {1'b0, a} + {1'b0, bb} + {64'd0, ci};
        v  = (a[63] == bb[63]) && (r[63] != a[63]);
        return {r[63:0], (r[63:0] == 64'd0), r[63], r[64], v};
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return ONES;
            1: return 64'd0;
            2: return MSB;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [67:0] q[$];
    logic [67:0] e;
    logic        model_c;
    int          accepted;
    int          cycles;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = OP_ADD; in_a = '0; in_b = '0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_flags", out_flags, 0);
        chk("rst_carry", carry_flag, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(OP_ADD, ONES, 64'd1);
        step();
        chk("addw_valid", out_valid, 1);
        chk("addw_sum", out_sum, 0);
        chk("addw_flags", out_flags, 4'b1010);
        chk("addw_carry", carry_flag, 1);

        drive(OP_SUB, MSB, 64'd1);
        step();
        chk("subov_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("subov_flags", out_flags, 4'b0011);

        drive(OP_ADD, ONES, 64'd1);
        step();
        chk("chain_lo_carry", carry_flag, 1);
        drive(OP_ADC, 64'd0, 64'd0);
        step();
        chk("adc_hi_sum", out_sum, 64'd1);
        chk("adc_hi_flags", out_flags, 4'b0000);
        chk("adc_hi_carry", carry_flag, 0);

        drive(OP_SUB, 64'd0, 64'd1);
        step();
        chk("sub_lo_sum", out_sum, ONES);
        chk("sub_lo_flags", out_flags, 4'b0100);
        drive(OP_SBC, 64'd5, 64'd0);
        step();
        chk("sbc_hi_sum", out_sum, 64'd4);
        chk("sbc_hi_flags", out_flags, 4'b0010);
        chk("sbc_hi_carry", carry_flag, 1);

        for (int i = 0; i < 3; i++) begin
            drive(OP_ADD, 64'd100 + 64'(i), 64'd7);
            out_ready = 1'b0;
            #1;
            chk("bp_ready", in_ready, 0);
            step();
            chk("bp_valid", out_valid, 1);
            chk("bp_sum", out_sum, 64'd4);
            chk("bp_flags", out_flags, 4'b0010);
            chk("bp_carry", carry_flag, 1);
        end
        drive(OP_ADD, 64'd10, 64'd20);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_release_valid", out_valid, 1);
        chk("bp_release_sum", out_sum, 64'd30);
        chk("bp_release_flags", out_flags, 4'b0000);
        chk("bp_release_carry", carry_flag, 0);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_sum_hold", out_sum, 64'd30);

        drive(OP_ADC, ONES, ONES);
        out_ready = 1'b0;
        step();
        chk("stall_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("stall_carry", carry_flag, 1);
        drive(OP_ADD, 64'd1, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_flags", out_flags, 0);
        chk("midrst_carry", carry_flag, 0);
        chk("midrst_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("midrst_noaccept", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;

        model_c = 1'b0;
        accepted = 0;
        cycles = 0;
        while ((accepted < 100 || q.size() != 0) && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (accepted < 100) && ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = pick_operand();
            in_b      = pick_operand();
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("strm_valid", out_valid, q.size() != 0);
            chk("strm_carry", carry_flag, model_c);
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("strm_sum", out_sum, e[67:4]);
                chk("strm_flags", out_flags, e[3:0]);
            end
            if (in_valid && in_ready) begin
                e = ref_op(in_op, in_a, in_b, model_c);
                q.push_back(e);
                model_c = e[1];
                accepted++;
            end
        end
        chk("strm_complete", cycles < 3000, 1);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
